// File: rtl/dbsao_pkg.sv
// Shared encodings and LCU geometry for the deblocking/SAO controller and its sub-stages.
package dbsao_pkg;

   typedef enum logic [2:0] {
      StIdle = 3'b000,
      StLoad = 3'b001,
      StDby  = 3'b010,
      StDbu  = 3'b011,
      StDbv  = 3'b100,
      StSao  = 3'b101,
      StOut  = 3'b110
   } dbsao_state_e;

   typedef enum logic [1:0] {
      PlaneY = 2'd0,
      PlaneU = 2'd1,
      PlaneV = 2'd2
   } plane_e;

   localparam logic [6:0] LumaSize   = 7'd64;
   localparam logic [6:0] ChromaSize = 7'd32;

   localparam logic [8:0] PhaseU   = 9'd64;
   localparam logic [8:0] PhaseV   = 9'd96;
   localparam logic [8:0] PhaseEnd = 9'd128;

   typedef struct packed {
      logic       vld;
      logic       rep;
      logic       last;
      plane_e     sel;
      logic [5:0] addr;
   } wr_token_t;

   // 4:2:0 chroma extent of a luma dimension, rounding up.
   function automatic logic [6:0] chroma_dim(input logic [6:0] luma);
      logic [7:0] s;
      s = {1'b0, luma} + 8'd1;
      return s[7:1];
   endfunction

endpackage

// File: rtl/dbsao_row_pad.sv
// Column edge replication of one reconstructed row; chroma rows occupy the low 32 pixels
// and their upper half is forced to zero.
module dbsao_row_pad
   import dbsao_pkg::*;
#(
   parameter int unsigned PIX_W = 8
) (
   input  logic [64*PIX_W-1:0] row_i,
   input  logic [6:0]          width_i,
   input  logic                chroma_i,
   output logic [64*PIX_W-1:0] row_o
);

   logic [6:0]       lim;
   logic [6:0]       eff_w;
   logic [5:0]       edge_idx;
   logic [PIX_W-1:0] edge_pix;

   always_comb begin
      lim = chroma_i ? ChromaSize : LumaSize;
      // Clamp out-of-range widths so the edge index always lands inside the plane.
      if (width_i == 7'd0) begin
         eff_w = 7'd1;
      end else if (width_i > lim) begin
         eff_w = lim;
      end else begin
         eff_w = width_i;
      end
      edge_idx = 6'(eff_w - 7'd1);

      edge_pix = '0;
      for (int c = 0; c < 64; c++) begin
         if (6'(c) == edge_idx) begin
            edge_pix = row_i[c*PIX_W +: PIX_W];
         end
      end

      row_o = '0;
      for (int c = 0; c < 64; c++) begin
         if (7'(c) >= lim) begin
            row_o[c*PIX_W +: PIX_W] = '0;
         end else if (7'(c) >= eff_w) begin
            row_o[c*PIX_W +: PIX_W] = edge_pix;
         end else begin
            row_o[c*PIX_W +: PIX_W] = row_i[c*PIX_W +: PIX_W];
         end
      end
   end

endmodule

// File: rtl/dbsao_lcu_loader.sv
// LOAD-phase row loader: reads one 4:2:0 LCU row per cycle, pads partial LCUs by edge
// replication and writes the working buffer. Define DBSAO_LOAD_CHECK_EN for sticky err_o.
module dbsao_lcu_loader
   import dbsao_pkg::*;
#(
   parameter int unsigned RD_LAT = 1,
   parameter int unsigned PIX_W  = 8
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [2:0]          state_i,
   input  logic [8:0]          cnt_i,
   input  logic [6:0]          lcu_w_i,
   input  logic [6:0]          lcu_h_i,
   output logic                rec_rd_en_o,
   output logic [1:0]          rec_rd_sel_o,
   output logic [5:0]          rec_rd_addr_o,
   input  logic [64*PIX_W-1:0] rec_rd_data_i,
   output logic                buf_wr_en_o,
   output logic [1:0]          buf_wr_sel_o,
   output logic [5:0]          buf_wr_addr_o,
   output logic [64*PIX_W-1:0] buf_wr_data_o,
   output logic                load_done_o
`ifdef DBSAO_LOAD_CHECK_EN
   ,
   output logic                err_o
`endif
);

   logic [6:0]          w_q;
   logic [6:0]          h_q;
   logic                in_load;
   logic                sample;
   logic [6:0]          cur_h;
   logic [6:0]          cur_ch;
   logic [6:0]          row_lim;
   logic                slot_vld;
   logic                row_vld;
   plane_e              slot_sel;
   logic [5:0]          slot_row;
   wr_token_t           slot_tok;
   wr_token_t           pipe_q [RD_LAT];
   wr_token_t           wr_tok;
   logic [6:0]          pad_w;
   logic                pad_chroma;
   logic [64*PIX_W-1:0] padded;
   logic [64*PIX_W-1:0] last_row_q;

   assign in_load = (state_i == StLoad);
   assign sample  = in_load && (cnt_i == 9'd0);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         w_q <= '0;
         h_q <= '0;
      end else if (sample) begin
         w_q <= lcu_w_i;
         h_q <= lcu_h_i;
      end
   end

   // Read slot decode; the cnt 0 slot already needs the height being sampled this cycle.
   always_comb begin
      cur_h    = sample ? lcu_h_i : h_q;
      cur_ch   = chroma_dim(cur_h);
      slot_vld = in_load && (cnt_i < PhaseEnd);
      slot_sel = PlaneY;
      slot_row = cnt_i[5:0];
      row_lim  = cur_h;
      if (cnt_i >= PhaseV) begin
         slot_sel = PlaneV;
         slot_row = {1'b0, cnt_i[4:0]};
         row_lim  = cur_ch;
      end else if (cnt_i >= PhaseU) begin
         slot_sel = PlaneU;
         slot_row = {1'b0, cnt_i[4:0]};
         row_lim  = cur_ch;
      end
      row_vld = ({1'b0, slot_row} < row_lim);

      slot_tok = '0;
      if (slot_vld) begin
         slot_tok.vld  = 1'b1;
         slot_tok.rep  = !row_vld;
         slot_tok.last = (cnt_i == PhaseEnd - 9'd1);
         slot_tok.sel  = slot_sel;
         slot_tok.addr = slot_row;
      end

      // Gated by reset so a mid-LOAD reset silences the read port at once.
      rec_rd_en_o   = rst_n && slot_vld && row_vld;
      rec_rd_sel_o  = rec_rd_en_o ? slot_sel : 2'd0;
      rec_rd_addr_o = rec_rd_en_o ? slot_row : 6'd0;
   end

   // Token pipeline matches the read latency and drains regardless of state_i.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < RD_LAT; i++) begin
            pipe_q[i] <= '0;
         end
      end else begin
         pipe_q[0] <= slot_tok;
         for (int i = 1; i < RD_LAT; i++) begin
            pipe_q[i] <= pipe_q[i-1];
         end
      end
   end

   assign wr_tok = pipe_q[RD_LAT-1];

   always_comb begin
      pad_chroma = (wr_tok.sel != PlaneY);
      pad_w      = pad_chroma ? chroma_dim(w_q) : w_q;
   end

   dbsao_row_pad #(
      .PIX_W(PIX_W)
   ) u_row_pad (
      .row_i   (rec_rd_data_i),
      .width_i (pad_w),
      .chroma_i(pad_chroma),
      .row_o   (padded)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         last_row_q <= '0;
      end else if (wr_tok.vld && !wr_tok.rep) begin
         last_row_q <= padded;
      end
   end

   always_comb begin
      buf_wr_en_o   = wr_tok.vld;
      buf_wr_sel_o  = wr_tok.sel;
      buf_wr_addr_o = wr_tok.addr;
      buf_wr_data_o = '0;
      if (wr_tok.vld) begin
         buf_wr_data_o = wr_tok.rep ? last_row_q : padded;
      end
      load_done_o = wr_tok.vld && wr_tok.last;
   end

`ifdef DBSAO_LOAD_CHECK_EN
   logic active_q;
   logic err_q;
   logic dim_bad;

   assign dim_bad = (lcu_w_i == 7'd0) || (lcu_w_i > LumaSize) ||
                    (lcu_h_i == 7'd0) || (lcu_h_i > LumaSize);

   // active_q spans from the sample slot up to the V row 31 read slot.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         active_q <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         if (sample) begin
            active_q <= 1'b1;
         end else if (!in_load || (cnt_i == PhaseEnd - 9'd1)) begin
            active_q <= 1'b0;
         end
         if ((sample && dim_bad) || (active_q && !in_load)) begin
            err_q <= 1'b1;
         end
      end
   end

   assign err_o = err_q;
`endif

endmodule

// File: tb/tb_dbsao_lcu_loader.sv
// Self-checking bench for dbsao_lcu_loader: RD_LAT=1 and RD_LAT=2 instances side by side.
module tb_dbsao_lcu_loader;

   localparam int PW = 8;
   localparam int RW = 64 * PW;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic [2:0]    state = 3'b000;
   logic [8:0]    cnt = '0;
   logic [6:0]    lw = 7'd64;
   logic [6:0]    lh = 7'd64;

   logic          rd_en   [2];
   logic [1:0]    rd_sel  [2];
   logic [5:0]    rd_addr [2];
   logic [RW-1:0] rd_data [2];
   logic [RW-1:0] rd_pipe2;
   logic          wr_en   [2];
   logic [1:0]    wr_sel  [2];
   logic [5:0]    wr_addr [2];
   logic [RW-1:0] wr_data [2];
   logic          done    [2];
`ifdef DBSAO_LOAD_CHECK_EN
   logic          err     [2];
`endif

   logic [RW-1:0] mem [4][64];

   int n_checks = 0;
   int n_errors = 0;
   int c_w, c_h, c_e;
   int nwr   [2];
   int ndone [2];

   always #5 clk = ~clk;

   dbsao_lcu_loader #(.RD_LAT(1), .PIX_W(PW)) u_dut1 (
      .clk(clk), .rst_n(rst_n), .state_i(state), .cnt_i(cnt),
      .lcu_w_i(lw), .lcu_h_i(lh),
      .rec_rd_en_o(rd_en[0]), .rec_rd_sel_o(rd_sel[0]), .rec_rd_addr_o(rd_addr[0]),
      .rec_rd_data_i(rd_data[0]),
      .buf_wr_en_o(wr_en[0]), .buf_wr_sel_o(wr_sel[0]), .buf_wr_addr_o(wr_addr[0]),
      .buf_wr_data_o(wr_data[0]), .load_done_o(done[0])
`ifdef DBSAO_LOAD_CHECK_EN
      , .err_o(err[0])
`endif
   );

   dbsao_lcu_loader #(.RD_LAT(2), .PIX_W(PW)) u_dut2 (
      .clk(clk), .rst_n(rst_n), .state_i(state), .cnt_i(cnt),
      .lcu_w_i(lw), .lcu_h_i(lh),
      .rec_rd_en_o(rd_en[1]), .rec_rd_sel_o(rd_sel[1]), .rec_rd_addr_o(rd_addr[1]),
      .rec_rd_data_i(rd_data[1]),
      .buf_wr_en_o(wr_en[1]), .buf_wr_sel_o(wr_sel[1]), .buf_wr_addr_o(wr_addr[1]),
      .buf_wr_data_o(wr_data[1]), .load_done_o(done[1])
`ifdef DBSAO_LOAD_CHECK_EN
      , .err_o(err[1])
`endif
   );

   // Reconstruction buffer with 1- and 2-cycle read latency.
   always @(posedge clk) begin
      rd_data[0] <= rd_en[0] ? mem[rd_sel[0]][rd_addr[0]] : '0;
      rd_pipe2   <= rd_en[1] ? mem[rd_sel[1]][rd_addr[1]] : '0;
      rd_data[1] <= rd_pipe2;
   end

   task automatic chk(input string name, input int k, input int j,
                      input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s inst=%0d cyc=%0d got=%h exp=%h", name, k, j, got, exp);
      end
   endtask

   task automatic chk_data(input string name, input int k, input int j,
                           input logic [RW-1:0] got, input logic [RW-1:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s inst=%0d cyc=%0d got=%h exp=%h", name, k, j, got, exp);
      end
   endtask

   function automatic int vdim(input int d, input int plane);
      return (plane == 0) ? d : (d + 1) / 2;
   endfunction

   function automatic void slot_map(input int s, output int plane, output int row);
      if (s < 64) begin
         plane = 0; row = s;
      end else if (s < 96) begin
         plane = 1; row = s - 64;
      end else begin
         plane = 2; row = s - 96;
      end
   endfunction

   function automatic logic [RW-1:0] pad_row(input logic [RW-1:0] r, input int vw,
                                             input bit chroma);
      logic [RW-1:0] o;
      int src;
      o = '0;
      for (int c = 0; c < 64; c++) begin
         if (!(chroma && c >= 32)) begin
            src = (c < vw) ? c : vw - 1;
            o[c*PW +: PW] = r[src*PW +: PW];
         end
      end
      return o;
   endfunction

   task automatic fill_mem(input int mode);
      for (int p = 0; p < 4; p++) begin
         for (int r = 0; r < 64; r++) begin
            for (int c = 0; c < 64; c++) begin
               mem[p][r][c*PW +: PW] = (mode == 0) ? PW'(r) : PW'($urandom);
            end
         end
      end
   endtask

   task automatic apply_reset();
      rst_n = 1'b0;
      state = 3'b000;
      cnt   = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      for (int k = 0; k < 2; k++) begin
         chk("reset_state", k, -1,
             32'({rd_en[k], rd_sel[k], rd_addr[k], wr_en[k], wr_sel[k], wr_addr[k],
                  done[k], |wr_data[k]}), 32'd0);
      end
   endtask

   task automatic drive(input int j);
      if (j < c_e && j <= 128) begin
         state = 3'b001;
         cnt   = 9'(j);
      end else if (c_e > 128) begin
         state = 3'b010;
         cnt   = 9'(j - 129);
      end else begin
         state = 3'b000;
         cnt   = '0;
      end
      // Off the sample slot the dimension inputs wander; the loader must hold its copy.
      if (j == 0) begin
         lw = 7'(c_w);
         lh = 7'(c_h);
      end else begin
         lw = 7'($urandom_range(1, 64));
         lh = 7'($urandom_range(1, 64));
      end
   endtask

   task automatic check_cycle(input int j);
      int p, r, s, vh, rr;
      logic [31:0] exp_rd, exp_wr;
      logic [RW-1:0] exp_d;
      for (int k = 0; k < 2; k++) begin
         exp_rd = '0;
         if (j < c_e && j < 128) begin
            slot_map(j, p, r);
            if (r < vdim(c_h, p)) exp_rd = 32'({1'b1, 2'(p), 6'(r)});
         end
         chk("rd_ctrl", k, j, 32'({rd_en[k], rd_sel[k], rd_addr[k]}), exp_rd);

         s = j - (k + 1);
         exp_wr = '0;
         exp_d  = '0;
         if (s >= 0 && s < 128 && s < c_e) begin
            slot_map(s, p, r);
            vh = vdim(c_h, p);
            rr = (r < vh) ? r : vh - 1;
            exp_wr = 32'({1'b1, 2'(p), 6'(r), s == 127});
            exp_d  = pad_row(mem[p][rr], vdim(c_w, p), p != 0);
         end
         chk("wr_ctrl", k, j, 32'({wr_en[k], wr_sel[k], wr_addr[k], done[k]}), exp_wr);
         chk_data("wr_data", k, j, wr_data[k], exp_d);
         if (wr_en[k]) nwr[k]++;
         if (done[k]) ndone[k]++;
      end
   endtask

   typedef struct {
      int w;
      int h;
      int e;
      int fill;
      int exp_writes;
      int exp_done;
      bit exp_err;
   } case_t;

   case_t cases [10];

   initial begin
      cases[0] = '{w: 64, h: 64, e: 129, fill: 0, exp_writes: 128, exp_done: 1, exp_err: 0};
      cases[1] = '{w: 20, h: 64, e: 129, fill: 1, exp_writes: 128, exp_done: 1, exp_err: 0};
      cases[2] = '{w: 64, h: 9,  e: 129, fill: 1, exp_writes: 128, exp_done: 1, exp_err: 0};
      cases[3] = '{w: 1,  h: 1,  e: 129, fill: 1, exp_writes: 128, exp_done: 1, exp_err: 0};
      cases[4] = '{w: 33, h: 47, e: 129, fill: 1, exp_writes: 128, exp_done: 1, exp_err: 0};
      cases[5] = '{w: 64, h: 64, e: 100, fill: 1, exp_writes: 100, exp_done: 0, exp_err: 1};
      for (int i = 6; i < 10; i++) begin
         cases[i] = '{w: int'($urandom_range(1, 64)), h: int'($urandom_range(1, 64)), e: 129,
                      fill: 1, exp_writes: 128, exp_done: 1, exp_err: 0};
      end

      for (int i = 0; i < 10; i++) begin
         apply_reset();
         fill_mem(cases[i].fill);
         c_w = cases[i].w;
         c_h = cases[i].h;
         c_e = cases[i].e;
         nwr   = '{0, 0};
         ndone = '{0, 0};
         for (int j = 0; j < ((c_e < 129) ? c_e : 129) + 4; j++) begin
            @(posedge clk);
            #1;
            drive(j);
            @(negedge clk);
            check_cycle(j);
         end
         for (int k = 0; k < 2; k++) begin
            chk("write_count", k, i, 32'(nwr[k]), 32'(cases[i].exp_writes));
            chk("done_count", k, i, 32'(ndone[k]), 32'(cases[i].exp_done));
`ifdef DBSAO_LOAD_CHECK_EN
            chk("err_after_case", k, i, 32'(err[k]), 32'(cases[i].exp_err));
`endif
         end
      end

      // Reset asserted mid-LOAD at cnt 40.
      apply_reset();
      fill_mem(1);
      c_w = 64;
      c_h = 64;
      c_e = 129;
      nwr   = '{0, 0};
      ndone = '{0, 0};
      for (int j = 0; j <= 40; j++) begin
         @(posedge clk);
         #1;
         drive(j);
         @(negedge clk);
         check_cycle(j);
      end
      #1 rst_n = 1'b0;
      #1;
      for (int k = 0; k < 2; k++) begin
         chk("rst_mid_zero", k, 40,
             32'({rd_en[k], rd_sel[k], rd_addr[k], wr_en[k], wr_sel[k], wr_addr[k],
                  done[k], |wr_data[k]}), 32'd0);
      end
      @(posedge clk);
      #1;
      state = 3'b000;
      cnt   = '0;
      @(negedge clk);
      #1 rst_n = 1'b1;
      for (int j = 0; j < 6; j++) begin
         @(negedge clk);
         for (int k = 0; k < 2; k++) begin
            chk("no_wr_after_rst", k, j, 32'({rd_en[k], wr_en[k], done[k]}), 32'd0);
         end
      end

`ifdef DBSAO_LOAD_CHECK_EN
      // Zero width sampled: err sets while LOAD is still running normally.
      apply_reset();
      @(posedge clk);
      #1;
      state = 3'b001;
      cnt   = 9'd0;
      lw    = 7'd0;
      lh    = 7'd64;
      @(negedge clk);
      for (int k = 0; k < 2; k++) chk("err_before_sample", k, 0, 32'(err[k]), 32'd0);
      @(posedge clk);
      #1;
      cnt = 9'd1;
      lw  = 7'd64;
      @(negedge clk);
      for (int k = 0; k < 2; k++) chk("err_zero_width", k, 1, 32'(err[k]), 32'd1);
      @(posedge clk);
      #1;
      state = 3'b000;
      cnt   = '0;
      repeat (3) @(negedge clk);
      for (int k = 0; k < 2; k++) chk("err_sticky", k, 5, 32'(err[k]), 32'd1);
`endif

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
